// File: rtl/vga_axil_slave_bridge.sv
// vga_axil_slave_bridge: AXI4-Lite slave driving a flat native register port.
// Define VGA_AXIL_SLAVE_BRIDGE_RANGE_CHECK_EN to answer out-of-window accesses with SLVERR.
module vga_axil_slave_bridge #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_REGS     = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       awaddr,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0]     wstrb,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic [ADDR_WIDTH-1:0]       araddr,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic [1:0]                  rresp,
  output logic                        rvalid,
  input  logic                        rready,
  output logic                        write_en,
  output logic [$clog2(NUM_REGS)-1:0] addr_write,
  output logic [DATA_WIDTH-1:0]       data2native,
  output logic [DATA_WIDTH/8-1:0]     byte_en,
  output logic                        read_en,
  output logic [$clog2(NUM_REGS)-1:0] addr_read,
  input  logic [DATA_WIDTH-1:0]       data2axil
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int IW  = $clog2(NUM_REGS);
  localparam int LSB = $clog2(SW);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS * SW);
  typedef enum logic [1:0] {W_COLLECT, W_EXEC, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_WAIT, R_RESP} rstate_t;
  wstate_t ws;
  rstate_t rs;
  logic aw_held, w_held, w_err, r_err;
  logic aw_hs, w_hs, ar_hs, aw_oor, ar_oor;
  logic [2:0] cnt;
  logic unused_addr_bits;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign unused_addr_bits = ^{awaddr, araddr};
`ifdef VGA_AXIL_SLAVE_BRIDGE_RANGE_CHECK_EN
  assign aw_oor = {1'b0, awaddr} >= LIMIT;
  assign ar_oor = {1'b0, araddr} >= LIMIT;
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif
  // AW and W are collected independently; EXEC starts once both are held
  always_ff @(posedge clk) begin
    if (rst) begin
      ws          <= W_COLLECT;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      w_err       <= 1'b0;
      awready     <= 1'b0;
      wready      <= 1'b0;
      write_en    <= 1'b0;
      bvalid      <= 1'b0;
      bresp       <= 2'b00;
      addr_write  <= '0;
      data2native <= '0;
      byte_en     <= '0;
    end else begin
      case (ws)
        W_COLLECT: begin
          if (aw_hs) begin
            aw_held    <= 1'b1;
            addr_write <= awaddr[LSB +: IW];
            w_err      <= aw_oor;
          end
          if (w_hs) begin
            w_held      <= 1'b1;
            data2native <= wdata;
            byte_en     <= wstrb;
          end
          awready <= !(aw_held || aw_hs);
          wready  <= !(w_held || w_hs);
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            ws       <= W_EXEC;
            write_en <= !(aw_hs ? aw_oor : w_err);
          end
        end
        W_EXEC: begin
          write_en <= 1'b0;
          bvalid   <= 1'b1;
          bresp    <= w_err ? 2'b10 : 2'b00;
          ws       <= W_RESP;
        end
        W_RESP: if (bready) begin
          bvalid  <= 1'b0;
          bresp   <= 2'b00;
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          awready <= 1'b1;
          wready  <= 1'b1;
          ws      <= W_COLLECT;
        end
        default: ws <= W_COLLECT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rs        <= R_IDLE;
      r_err     <= 1'b0;
      cnt       <= '0;
      arready   <= 1'b0;
      read_en   <= 1'b0;
      addr_read <= '0;
      rvalid    <= 1'b0;
      rresp     <= 2'b00;
      rdata     <= '0;
    end else begin
      case (rs)
        R_IDLE: begin
          arready <= !ar_hs;
          if (ar_hs) begin
            addr_read <= araddr[LSB +: IW];
            r_err     <= ar_oor;
            read_en   <= !ar_oor;
            rs        <= R_EXEC;
          end
        end
        R_EXEC: begin
          read_en <= 1'b0;
          cnt     <= '0;
          rs      <= R_WAIT;
        end
        // native data is valid on the last of READ_LATENCY wait cycles
        R_WAIT: begin
          if (cnt == 3'(READ_LATENCY - 1)) begin
            rdata  <= r_err ? '0 : data2axil;
            rresp  <= r_err ? 2'b10 : 2'b00;
            rvalid <= 1'b1;
            rs     <= R_RESP;
          end else cnt <= cnt + 3'd1;
        end
        R_RESP: if (rready) begin
          rvalid  <= 1'b0;
          rresp   <= 2'b00;
          arready <= 1'b1;
          rs      <= R_IDLE;
        end
        default: rs <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_axil_slave_bridge.sv
// tb_vga_axil_slave_bridge: directed and randomized AXI-Lite traffic against a word-array reference model.
module tb_vga_axil_slave_bridge;
  localparam int L = 3;
`ifdef VGA_AXIL_SLAVE_BRIDGE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [15:0] awaddr = 0, araddr = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid, write_en, read_en;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, data2native, data2axil;
  logic [3:0] byte_en;
  logic [5:0] addr_write, addr_read;
  int cyc = 0, errors = 0, checks = 0;
  int we_n = 0, re_n = 0, we_cyc = -1, re_cyc = -1;
  logic [5:0] we_a;
  logic [31:0] we_d;
  logic [3:0] we_b;
  logic [31:0] nat_mem[64] = '{default: 32'h0};
  logic [31:0] ref_mem[64] = '{default: 32'h0};
  logic [L-1:0] pv = '0;
  logic [5:0] pa[L];

  always #5 clk = ~clk;

  vga_axil_slave_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .NUM_REGS(64), .READ_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .write_en(write_en), .addr_write(addr_write), .data2native(data2native), .byte_en(byte_en),
    .read_en(read_en), .addr_read(addr_read), .data2axil(data2axil)
  );

  // native register file: data only present exactly L cycles after read_en
  assign data2axil = pv[L-1] ? nat_mem[pa[L-1]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pv <= {pv[L-2:0], read_en};
    pa[0] <= addr_read;
    for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
    if (read_en) begin
      re_n <= re_n + 1;
      re_cyc <= cyc;
    end
    if (write_en) begin
      we_n <= we_n + 1;
      we_cyc <= cyc;
      we_a <= addr_write;
      we_d <= data2native;
      we_b <= byte_en;
      for (int b = 0; b < 4; b++) if (byte_en[b]) nat_mem[addr_write][8*b +: 8] <= data2native[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_gap, input int w_gap, input int b_stall);
    int aw_acc = -1, w_acc = -1, acc, we0 = we_n;
    bit err = RC && (a >= 16'h0100);
    int idx = (int'(a) / 4) % 64;
    awaddr = a; wdata = d; wstrb = s;
    for (int k = 0; k < 40 && (aw_acc < 0 || w_acc < 0); k++) begin
      logic ah, wh;
      awvalid = (aw_acc < 0) && (k >= aw_gap);
      wvalid = (w_acc < 0) && (k >= w_gap);
      if (w_acc >= 0 && aw_acc < 0) check("wready_while_held", wready, 0);
      if (aw_acc >= 0 && w_acc < 0) check("awready_while_held", awready, 0);
      ah = awvalid && awready;
      wh = wvalid && wready;
      tick();
      if (ah) aw_acc = cyc;
      if (wh) w_acc = cyc;
    end
    awvalid = 0; wvalid = 0;
    check("write_accepted", (aw_acc >= 0) && (w_acc >= 0), 1);
    acc = aw_acc > w_acc ? aw_acc : w_acc;
    for (int k = 0; k < 20 && !bvalid; k++) tick();
    check("b_latency", cyc, acc + 1);
    check("bresp", bresp, err ? 2 : 0);
    for (int k = 0; k < b_stall; k++) begin
      tick();
      check("b_stall_stable", {bvalid, bresp}, {1'b1, err ? 2'd2 : 2'd0});
    end
    bready = 1;
    tick();
    bready = 0;
    check("bvalid_drop", bvalid, 0);
    check("we_count", we_n - we0, err ? 0 : 1);
    if (!err) begin
      check("we_cycle", we_cyc, acc);
      check("we_addr", we_a, idx);
      check("we_data", we_d, d);
      check("we_be", we_b, s);
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic axi_read(input logic [15:0] a, input int r_stall);
    int ar_acc = -1, re0 = re_n;
    bit err = RC && (a >= 16'h0100);
    logic [31:0] expd = err ? 32'h0 : ref_mem[(int'(a) / 4) % 64];
    araddr = a;
    arvalid = 1;
    for (int k = 0; k < 20 && ar_acc < 0; k++) begin
      logic h;
      h = arready;
      tick();
      if (h) ar_acc = cyc;
    end
    arvalid = 0;
    check("read_accepted", ar_acc >= 0, 1);
    for (int k = 0; k < 20 && !rvalid; k++) tick();
    check("r_latency", cyc, ar_acc + 1 + L);
    check("rdata", rdata, expd);
    check("rresp", rresp, err ? 2 : 0);
    for (int k = 0; k < r_stall; k++) begin
      tick();
      check("r_stall_stable", {rvalid, rresp, rdata}, {1'b1, err ? 2'd2 : 2'd0, expd});
    end
    rready = 1;
    tick();
    rready = 0;
    check("rvalid_drop", rvalid, 0);
    check("re_count", re_n - re0, err ? 0 : 1);
    if (!err) check("re_cycle", re_cyc, ar_acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int re0;
    tick(); tick();
    check("rst_outputs", {awready, wready, arready, bvalid, rvalid, write_en, read_en}, 0);
    rst = 0;
    tick();
    check("readies_after_rst", {awready, wready, arready}, 3'b111);
    axi_write(16'h0008, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_write(16'h000C, 32'h11223344, 4'h5, 3, 0, 0);
    axi_write(16'h0008, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    axi_read(16'h0008, 4);
    axi_read(16'h000C, 0);
    fork
      axi_write(16'h0010, 32'h0BADCAFE, 4'hF, 0, 0, 3);
      axi_read(16'h0004, 2);
    join
    check("concurrent_strobes", we_cyc, re_cyc);
    axi_write(16'h0100, 32'h55AA55AA, 4'hF, 0, 0, 1);
    axi_read(16'h0100, 0);
    axi_read(16'h0010, 0);
    // reset while the read engine waits on native data
    araddr = 16'h0008;
    arvalid = 1;
    check("arready_idle", arready, 1);
    tick();
    arvalid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_outputs", {awready, wready, arready, bvalid, rvalid, write_en, read_en, rdata}, 0);
    re0 = re_n;
    tick();
    check("mid_rst_readies", {awready, wready, arready, write_en, read_en}, 5'b11100);
    for (int k = 0; k < 8; k++) begin
      check("no_rvalid_after_rst", rvalid, 0);
      tick();
    end
    check("no_read_en_after_rst", re_n - re0, 0);
    axi_read(16'h0008, 0);
    for (int n = 0; n < 30; n++) begin
      logic [15:0] wa, ra;
      int op;
      wa = 16'($urandom_range(0, 16'h01FF));
      ra = 16'($urandom_range(0, 16'h01FF));
      op = $urandom_range(0, 2);
      if (op == 0)
        axi_write(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op == 1)
        axi_read(ra, $urandom_range(0, 3));
      else
        fork
          axi_write(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
          axi_read(wa ^ 16'h0004, $urandom_range(0, 3));
        join
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
